// File: rtl/writeback_unit.sv
// Writeback stage: extracts and extends load data, selects the destination
// register, queues pending register-file writes in a small in-order buffer,
// and offers a forwarding lookup over the writes still waiting in it.
module writeback_unit #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_opcode,
   input  logic [ADDR_W-1:0] in_rt,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic              in_reg_dst,
   input  logic              in_reg_write,
   input  logic              in_mem_to_reg,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_mem_data,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   input  logic [ADDR_W-1:0] fwd_rs,
   input  logic [ADDR_W-1:0] fwd_rt,
   output logic              fwd_hit_1,
   output logic [DATA_W-1:0] fwd_data_1,
   output logic              fwd_hit_2,
   output logic [DATA_W-1:0] fwd_data_2,
   output logic              err_align
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_LL  = 6'h30;

   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [PW:0]       r_count;
   logic              r_err;

   logic [ADDR_W-1:0] w_dest;
   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   logic [1:0]        w_lane;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [DATA_W-1:0] w_value;
   logic              w_misalign;
   logic [PW-1:0]     w_idx;
   logic              w_hit_1;
   logic              w_hit_2;
   logic [DATA_W-1:0] w_data_1;
   logic [DATA_W-1:0] w_data_2;

   assign in_ready = rst_n && (r_count < DEPTH_C);
   assign wb_valid = rst_n && (r_count != '0);
   assign wb_addr  = wb_valid ? r_addr[r_rptr] : '0;
   assign wb_data  = wb_valid ? r_data[r_rptr] : '0;

   assign w_dest   = in_reg_dst ? in_rd : in_rt;
   assign w_accept = in_valid && in_ready;
   assign w_push   = w_accept && in_reg_write && (w_dest != '0);
   assign w_pop    = wb_valid && wb_ready;

   // Select the addressed byte/half lane and extend it to a full register value.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_lane     = in_alu_result[1:0];
      w_byte     = 8'(in_mem_data >> {w_lane, 3'b000});
      w_half     = 16'(in_mem_data >> {w_lane[1], 4'b0000});
      w_value    = in_alu_result;
      w_misalign = 1'b0;
      if (in_mem_to_reg) begin
         w_value = in_mem_data;
         case (in_opcode)
            OP_LB:  w_value = {{24{w_byte[7]}}, w_byte};
            OP_LBU: w_value = {24'h0, w_byte};
            OP_LH: begin
               w_value    = {{16{w_half[15]}}, w_half};
               w_misalign = w_lane[0];
            end
            OP_LHU: begin
               w_value    = {16'h0, w_half};
               w_misalign = w_lane[0];
            end
            OP_LW, OP_LL: w_misalign = (w_lane != 2'b00);
            default: w_value = in_mem_data;
         endcase
      end
   end

   // Buffer storage: written on push only.
   always_ff @(posedge clk) begin
      // NOTE: the entry array is not reset; validity comes from the reset pointers/count alone.
      if (w_push) begin
         r_addr[r_wptr] <= w_dest;
         r_data[r_wptr] <= w_value;
      end
   end

   // Pointers, occupancy and the sticky alignment flag.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_accept && in_mem_to_reg && w_misalign) r_err <= 1'b1;
      end
   end

   // Forwarding lookup: scan oldest to youngest so the youngest match wins.
   always_comb begin
      w_hit_1  = 1'b0;
      w_hit_2  = 1'b0;
      w_data_1 = '0;
      w_data_2 = '0;
      w_idx    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_rptr + PW'(k);
         if ((PW+1)'(k) < r_count) begin
            if ((fwd_rs != '0) && (r_addr[w_idx] == fwd_rs)) begin
               w_hit_1  = 1'b1;
               w_data_1 = r_data[w_idx];
            end
            if ((fwd_rt != '0) && (r_addr[w_idx] == fwd_rt)) begin
               w_hit_2  = 1'b1;
               w_data_2 = r_data[w_idx];
            end
         end
      end
   end

   assign fwd_hit_1  = rst_n && w_hit_1;
   assign fwd_hit_2  = rst_n && w_hit_2;
   assign fwd_data_1 = rst_n ? w_data_1 : '0;
   assign fwd_data_2 = rst_n ? w_data_2 : '0;
   assign err_align  = r_err;

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the writeback buffer.
module tb_writeback_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_opcode;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic        in_reg_dst;
   logic        in_reg_write;
   logic        in_mem_to_reg;
   logic [31:0] in_alu_result;
   logic [31:0] in_mem_data;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [4:0]  fwd_rs;
   logic [4:0]  fwd_rt;
   logic        fwd_hit_1;
   logic [31:0] fwd_data_1;
   logic        fwd_hit_2;
   logic [31:0] fwd_data_2;
   logic        err_align;

   writeback_unit #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
      .in_rt(in_rt), .in_rd(in_rd), .in_reg_dst(in_reg_dst),
      .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
      .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
      .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
      .fwd_hit_1(fwd_hit_1), .fwd_data_1(fwd_data_1),
      .fwd_hit_2(fwd_hit_2), .fwd_data_2(fwd_data_2),
      .err_align(err_align)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   ent_t m_q[$];
   logic m_err;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   // Value a retiring instruction writes, straight from the load rules.
   function automatic logic [31:0] ref_value(input logic [5:0] op, input logic m2r,
                                             input logic [31:0] alu, input logic [31:0] mem);
      int unsigned a, b, h;
      if (!m2r) return alu;
      a = alu % 4;
      b = (mem / (32'd1 << (8 * a))) % 256;
      h = (a >= 2) ? (mem / 65536) : (mem % 65536);
      case (op)
         6'h20: return (b >= 128) ? (32'hFFFF_FF00 + b) : b;
         6'h24: return b;
         6'h21: return (h >= 32768) ? (32'hFFFF_0000 + h) : h;
         6'h25: return h;
         default: return mem;
      endcase
   endfunction

   function automatic bit ref_misalign(input logic [5:0] op, input logic m2r, input logic [31:0] alu);
      if (!m2r) return 0;
      if (op == 6'h21 || op == 6'h25) return (alu % 2) != 0;
      if (op == 6'h23 || op == 6'h30) return (alu % 4) != 0;
      return 0;
   endfunction

   // Called at a falling edge: compare outputs, then advance model across the rising edge.
   task automatic cycle();
      bit          exp_ready, exp_valid, h1, h2, acc, pop;
      logic [31:0] d1, d2;
      logic [4:0]  dest;
      #1;
      exp_ready = rst_n && (m_q.size() < DEPTH);
      exp_valid = rst_n && (m_q.size() > 0);
      h1 = 0; h2 = 0; d1 = 0; d2 = 0;
      if (rst_n) begin
         foreach (m_q[i]) begin
            if (fwd_rs != 0 && m_q[i].addr == fwd_rs) begin h1 = 1; d1 = m_q[i].data; end
            if (fwd_rt != 0 && m_q[i].addr == fwd_rt) begin h2 = 1; d2 = m_q[i].data; end
         end
      end
      check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
      check("wb_valid", {31'b0, wb_valid}, {31'b0, exp_valid});
      if (!rst_n) begin
         check("wb_addr_rst", {27'b0, wb_addr}, 32'h0);
         check("wb_data_rst", wb_data, 32'h0);
      end else if (exp_valid) begin
         check("wb_addr", {27'b0, wb_addr}, {27'b0, m_q[0].addr});
         check("wb_data", wb_data, m_q[0].data);
      end
      check("fwd_hit_1", {31'b0, fwd_hit_1}, {31'b0, h1});
      check("fwd_data_1", fwd_data_1, d1);
      check("fwd_hit_2", {31'b0, fwd_hit_2}, {31'b0, h2});
      check("fwd_data_2", fwd_data_2, d2);
      check("err_align", {31'b0, err_align}, {31'b0, m_err});
      @(posedge clk);
      acc  = in_valid && exp_ready;
      pop  = exp_valid && wb_ready;
      dest = in_reg_dst ? in_rd : in_rt;
      if (!rst_n) begin
         m_q.delete();
         m_err = 0;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (acc && in_reg_write && dest != 0)
            m_q.push_back('{addr: dest, data: ref_value(in_opcode, in_mem_to_reg, in_alu_result, in_mem_data)});
         if (acc && ref_misalign(in_opcode, in_mem_to_reg, in_alu_result)) m_err = 1;
      end
      @(negedge clk);
   endtask

   task automatic set_item(input logic [5:0] op, input logic rdst, input logic [4:0] rt,
                           input logic [4:0] rd, input logic rw, input logic m2r,
                           input logic [31:0] alu, input logic [31:0] mem);
      in_opcode = op; in_reg_dst = rdst; in_rt = rt; in_rd = rd;
      in_reg_write = rw; in_mem_to_reg = m2r; in_alu_result = alu; in_mem_data = mem;
   endtask

   // Push one load with the write port stalled, check the extended value, then drain it.
   task automatic load_one(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] exp);
      set_item(op, 1'b1, 5'd0, 5'd6, 1'b1, 1'b1, alu, 32'h80F1_7F82);
      in_valid = 1; wb_ready = 0;
      cycle();
      in_valid = 0;
      #1 check("load_value", wb_data, exp);
      wb_ready = 1;
      cycle();
      wb_ready = 0;
   endtask

   initial begin
      m_err = 0;
      rst_n = 0; in_valid = 0; wb_ready = 0; fwd_rs = 0; fwd_rt = 0;
      set_item(6'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      cycle(); cycle();
      rst_n = 1;

      // Single ALU op with one cycle latency.
      set_item(6'h0, 1'b1, 5'd0, 5'd5, 1'b1, 1'b0, 32'h1234_5678, 32'h0);
      in_valid = 1; wb_ready = 1;
      cycle();
      in_valid = 0;
      #1;
      check("alu_valid", {31'b0, wb_valid}, 32'd1);
      check("alu_addr", {27'b0, wb_addr}, 32'd5);
      check("alu_data", wb_data, 32'h1234_5678);
      cycle();
      #1 check("alu_drained", {31'b0, wb_valid}, 32'd0);
      wb_ready = 0;

      // Load lane extraction from 0x80F17F82.
      load_one(6'h20, 32'h0000_1001, 32'h0000_007F);
      load_one(6'h20, 32'h0000_1000, 32'hFFFF_FF82);
      load_one(6'h24, 32'h0000_1000, 32'h0000_0082);
      load_one(6'h21, 32'h0000_1002, 32'hFFFF_80F1);
      load_one(6'h25, 32'h0000_1002, 32'h0000_80F1);
      #1 check("no_align_err", {31'b0, err_align}, 32'd0);

      // Backpressure: third item waits for a free slot, writes come out in order.
      in_valid = 1; wb_ready = 0;
      set_item(6'h0, 1'b1, 5'd0, 5'd1, 1'b1, 1'b0, 32'h11, 32'h0); cycle();
      set_item(6'h0, 1'b1, 5'd0, 5'd2, 1'b1, 1'b0, 32'h22, 32'h0); cycle();
      #1 check("full_ready", {31'b0, in_ready}, 32'd0);
      set_item(6'h0, 1'b1, 5'd0, 5'd3, 1'b1, 1'b0, 32'h33, 32'h0); cycle();
      wb_ready = 1;
      #1 check("order_1", {27'b0, wb_addr}, 32'd1);
      cycle();
      #1 check("order_2", {27'b0, wb_addr}, 32'd2);
      cycle();
      in_valid = 0;
      #1 check("order_3", {27'b0, wb_addr}, 32'd3);
      cycle();
      #1 check("order_empty", {31'b0, wb_valid}, 32'd0);

      // Forwarding picks the youngest of two writes to the same register.
      wb_ready = 0; in_valid = 1;
      set_item(6'h0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 32'hA, 32'h0); cycle();
      set_item(6'h0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 32'hB, 32'h0); cycle();
      in_valid = 0; fwd_rs = 7; fwd_rt = 0;
      #1;
      check("fwd_young_hit", {31'b0, fwd_hit_1}, 32'd1);
      check("fwd_young_data", fwd_data_1, 32'hB);
      check("fwd_zero_hit", {31'b0, fwd_hit_2}, 32'd0);
      wb_ready = 1;
      cycle(); cycle();

      // Dropped items and sticky misalignment.
      in_valid = 1;
      set_item(6'h0, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 32'h55, 32'h0); cycle();
      set_item(6'h0, 1'b1, 5'd0, 5'd4, 1'b0, 1'b0, 32'h66, 32'h0); cycle();
      in_valid = 0;
      #1 check("drop_no_write", {31'b0, wb_valid}, 32'd0);
      in_valid = 1;
      set_item(6'h23, 1'b1, 5'd0, 5'd9, 1'b1, 1'b1, 32'h0000_2002, 32'hCAFE_F00D); cycle();
      in_valid = 0;
      #1;
      check("lw_misalign_err", {31'b0, err_align}, 32'd1);
      check("lw_misalign_data", wb_data, 32'hCAFE_F00D);
      cycle(); cycle();
      #1 check("err_sticky", {31'b0, err_align}, 32'd1);

      // Reset with two writes pending.
      wb_ready = 0; in_valid = 1;
      set_item(6'h0, 1'b1, 5'd0, 5'd10, 1'b1, 1'b0, 32'h1, 32'h0); cycle();
      set_item(6'h0, 1'b1, 5'd0, 5'd11, 1'b1, 1'b0, 32'h2, 32'h0); cycle();
      in_valid = 0; rst_n = 0;
      #1 check("rst_drop_valid", {31'b0, wb_valid}, 32'd0);
      cycle();
      rst_n = 1;
      #1;
      check("rst_ready", {31'b0, in_ready}, 32'd1);
      check("rst_empty", {31'b0, wb_valid}, 32'd0);
      check("rst_err_clear", {31'b0, err_align}, 32'd0);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 2000; n++) begin
         logic [5:0] op;
         case ($urandom_range(0, 6))
            0: op = 6'h20; 1: op = 6'h24; 2: op = 6'h21; 3: op = 6'h25;
            4: op = 6'h23; 5: op = 6'h30; default: op = 6'($urandom);
         endcase
         rst_n    = ($urandom_range(0, 63) != 0);
         in_valid = ($urandom_range(0, 3) != 0);
         wb_ready = ($urandom_range(0, 2) != 0);
         fwd_rs   = 5'($urandom_range(0, 7));
         fwd_rt   = 5'($urandom_range(0, 7));
         set_item(op, 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) != 0), 1'($urandom), $urandom, $urandom);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
